// File: rtl/itcm_fetch_resp_pkg.sv
// Shared widths, ITCM window defaults and FSM encoding for the fetch-side ITCM responder.
package itcm_fetch_resp_pkg;

  localparam int          ADDR_WIDTH      = 32;
  localparam int          INSTR_WIDTH     = 32;
  localparam logic [31:0] ITCM_START_ADDR = 32'h0000_0000;
  localparam int          ITCM_SIZE       = 4096;  // bytes
  localparam logic [31:0] LOAD_SRC_ADDR   = 32'h0010_0000;

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } fsm_state_e;

endpackage

// File: rtl/itcm_ram.sv
// Single-port ITCM storage: one registered read or write per cycle, write-first.
// Latency 1 cycle from address to rdata; no backpressure.
module itcm_ram #(
  parameter int DEPTH = 1024,
  parameter int WIDTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_q;
  logic [WIDTH-1:0] rdata_d;

  always_comb begin
    rdata_d = we ? wdata : mem[addr];
  end

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/itcm_fetch_resp.sv
// Fetch-side ITCM responder: auto-loads the image after reset, then serves one fetch per cycle.
// Fetch latency exactly 1 cycle, fully pipelined; no backpressure, load bus paced by load_rdata_valid.
module itcm_fetch_resp #(
  parameter int                    ADDR_WIDTH      = itcm_fetch_resp_pkg::ADDR_WIDTH,
  parameter int                    INSTR_WIDTH     = itcm_fetch_resp_pkg::INSTR_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] ITCM_START_ADDR = itcm_fetch_resp_pkg::ITCM_START_ADDR,
  parameter int                    ITCM_DEPTH      = itcm_fetch_resp_pkg::ITCM_SIZE / 4,
  parameter logic [ADDR_WIDTH-1:0] LOAD_SRC_ADDR   = itcm_fetch_resp_pkg::LOAD_SRC_ADDR,
  parameter int                    LOAD_WORDS      = itcm_fetch_resp_pkg::ITCM_SIZE / 4
) (
  input  logic                   cpu_clk,
  input  logic                   cpu_rst,
  input  logic                   instr_itcm_access,
  input  logic [ADDR_WIDTH-1:0]  instr_itcm_addr,
  output logic [INSTR_WIDTH-1:0] instr_itcm_read_data,
  output logic                   instr_itcm_read_data_valid,
  output logic                   itcm_auto_load,
  output logic                   load_req,
  output logic [ADDR_WIDTH-1:0]  load_addr,
  input  logic [INSTR_WIDTH-1:0] load_rdata,
  input  logic                   load_rdata_valid
);

  import itcm_fetch_resp_pkg::*;

  localparam int               IDX_W       = $clog2(ITCM_DEPTH);
  localparam int               CNT_W       = IDX_W + 1;
  localparam logic [CNT_W-1:0] LAST_CNT    = (LOAD_WORDS == 0) ? '0 : CNT_W'(LOAD_WORDS - 1);
  localparam fsm_state_e       RESET_STATE = (LOAD_WORDS == 0) ? ST_RUN : ST_LOAD;
  localparam logic             RESET_LOAD  = (LOAD_WORDS != 0);

  fsm_state_e            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  load_active_q, load_active_d;
  logic [ADDR_WIDTH-1:0] load_addr_q, load_addr_d;
  logic                  valid_q, valid_d;

  logic [ADDR_WIDTH-1:0]  word_off;
  logic                   fetch_hit;
  logic                   ram_we;
  logic [IDX_W-1:0]       ram_addr;
  logic [INSTR_WIDTH-1:0] ram_rdata;

  // Range test on the full word offset so any address past the window misses.
  always_comb begin
    word_off  = (instr_itcm_addr - ITCM_START_ADDR) >> 2;
    fetch_hit = instr_itcm_access
             && (instr_itcm_addr >= ITCM_START_ADDR)
             && (word_off < ADDR_WIDTH'(ITCM_DEPTH));
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    load_active_d = load_active_q;
    load_addr_d   = load_addr_q;
    valid_d       = 1'b0;
    ram_we        = 1'b0;
    ram_addr      = word_off[IDX_W-1:0];

    case (state_q)
      ST_LOAD: begin
        ram_addr = cnt_q[IDX_W-1:0];
        if (load_rdata_valid) begin
          ram_we      = !cpu_rst;
          cnt_d       = cnt_q + 1'b1;
          load_addr_d = LOAD_SRC_ADDR + (ADDR_WIDTH'(cnt_d) << 2);
          if (cnt_q == LAST_CNT) begin
            state_d       = ST_RUN;
            load_active_d = 1'b0;
          end
        end
      end
      ST_RUN: begin
        valid_d = fetch_hit;
      end
      default: begin
        state_d = RESET_STATE;
      end
    endcase
  end

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      state_q       <= RESET_STATE;
      cnt_q         <= '0;
      load_active_q <= RESET_LOAD;
      load_addr_q   <= LOAD_SRC_ADDR;
      valid_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      load_active_q <= load_active_d;
      load_addr_q   <= load_addr_d;
      valid_q       <= valid_d;
    end
  end

  itcm_ram #(
    .DEPTH (ITCM_DEPTH),
    .WIDTH (INSTR_WIDTH),
    .AW    (IDX_W)
  ) u_itcm_ram (
    .clk   (cpu_clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (load_rdata),
    .rdata (ram_rdata)
  );

  assign instr_itcm_read_data       = valid_q ? ram_rdata : '0;
  assign instr_itcm_read_data_valid = valid_q;
  assign itcm_auto_load             = load_active_q;
  assign load_req                   = load_active_q;
  assign load_addr                  = load_addr_q;

endmodule

// File: tb/tb_itcm_fetch_resp.sv
// Randomized scoreboard bench for itcm_fetch_resp against an array model of the ITCM image.
module tb_itcm_fetch_resp;

  localparam int          DEPTH = 1024;
  localparam int          LW    = 1024;
  localparam logic [31:0] SRC   = 32'h0010_0000;

  logic        cpu_clk = 1'b0;
  logic        cpu_rst = 1'b1;
  logic        instr_itcm_access = 1'b0;
  logic [31:0] instr_itcm_addr = 32'h0;
  logic [31:0] instr_itcm_read_data;
  logic        instr_itcm_read_data_valid;
  logic        itcm_auto_load;
  logic        load_req;
  logic [31:0] load_addr;
  logic [31:0] load_rdata = 32'h0;
  logic        load_rdata_valid = 1'b0;

  always #5 cpu_clk = ~cpu_clk;

  itcm_fetch_resp #(
    .ADDR_WIDTH      (32),
    .INSTR_WIDTH     (32),
    .ITCM_START_ADDR (32'h0000_0000),
    .ITCM_DEPTH      (DEPTH),
    .LOAD_SRC_ADDR   (SRC),
    .LOAD_WORDS      (LW)
  ) dut (
    .cpu_clk                    (cpu_clk),
    .cpu_rst                    (cpu_rst),
    .instr_itcm_access          (instr_itcm_access),
    .instr_itcm_addr            (instr_itcm_addr),
    .instr_itcm_read_data       (instr_itcm_read_data),
    .instr_itcm_read_data_valid (instr_itcm_read_data_valid),
    .itcm_auto_load             (itcm_auto_load),
    .load_req                   (load_req),
    .load_addr                  (load_addr),
    .load_rdata                 (load_rdata),
    .load_rdata_valid           (load_rdata_valid)
  );

  typedef struct {
    int unsigned cyc;
    logic        vld;
    logic [31:0] dat;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] img [DEPTH];
  logic [31:0] itcm_model [DEPTH];
  int unsigned cyc = 0;
  int          errors = 0;
  int          checks = 0;

  always @(posedge cpu_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Scoreboard monitor: each expectation belongs to the cycle after it was issued.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge cpu_clk);
      if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        e = exp_q.pop_front();
        chk("fetch_valid", {31'h0, instr_itcm_read_data_valid}, {31'h0, e.vld});
        chk("fetch_data", instr_itcm_read_data, e.dat);
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    case ($urandom_range(0, 7))
      0, 1, 2: a = {20'h0, 10'($urandom_range(0, DEPTH - 1)), 2'b00};
      3:       a = {20'h0, 12'($urandom)};
      4:       a = 32'h0000_0FFC;
      5:       a = 32'h0000_1000;
      6:       a = 32'h0000_1000 + 32'($urandom_range(0, 4096));
      default: a = $urandom;
    endcase
    return a;
  endfunction

  // The response model: a hit only when running and inside the 4 KiB window.
  task automatic issue_fetch(input bit acc, input logic [31:0] a, input bit running);
    exp_t e;
    bit   hit;
    instr_itcm_access = acc;
    instr_itcm_addr   = a;
    hit   = running && acc && (a < 32'(DEPTH * 4));
    e.cyc = cyc;
    e.vld = hit;
    e.dat = hit ? itcm_model[a[11:2]] : 32'h0;
    exp_q.push_back(e);
  endtask

  task automatic new_image();
    for (int i = 0; i < DEPTH; i++) img[i] = $urandom;
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge cpu_clk);
      if (i > 0) begin
        chk("rst_auto_load", {31'h0, itcm_auto_load}, 32'h1);
        chk("rst_load_req", {31'h0, load_req}, 32'h1);
        chk("rst_load_addr", load_addr, SRC);
      end
      cpu_rst          = 1'b1;
      load_rdata_valid = 1'b0;
      issue_fetch(1'($urandom_range(0, 1)), rand_addr(), 1'b0);
    end
  endtask

  task automatic load_image(input int nwords, input int max_gap);
    int gap;
    for (int k = 0; k < nwords; k++) begin
      gap = (k == 0) ? 0 : ((k < 8) ? max_gap : $urandom_range(0, max_gap));
      for (int g = 0; g < gap; g++) begin
        @(negedge cpu_clk);
        chk("gap_load_req", {31'h0, load_req}, 32'h1);
        chk("gap_load_addr", load_addr, SRC + 32'(4 * k));
        cpu_rst          = 1'b0;
        load_rdata_valid = 1'b0;
        load_rdata       = $urandom;
        issue_fetch(1'($urandom_range(0, 1)), rand_addr(), 1'b0);
      end
      @(negedge cpu_clk);
      chk("load_addr", load_addr, SRC + 32'(4 * k));
      chk("load_req", {31'h0, load_req}, 32'h1);
      chk("auto_load", {31'h0, itcm_auto_load}, 32'h1);
      cpu_rst          = 1'b0;
      load_rdata_valid = 1'b1;
      load_rdata       = img[k];
      itcm_model[k]    = img[k];
      issue_fetch(1'($urandom_range(0, 1)), rand_addr(), 1'b0);
    end
  endtask

  // First RUN cycles: back-to-back sequential fetches, then the window edges.
  task automatic directed_run();
    logic [31:0] seq [6];
    seq[0] = 32'h0; seq[1] = 32'h4; seq[2] = 32'h8;
    seq[3] = 32'hC; seq[4] = 32'hFFC; seq[5] = 32'h1000;
    for (int i = 0; i < 6; i++) begin
      @(negedge cpu_clk);
      if (i == 0) begin
        chk("run_auto_load", {31'h0, itcm_auto_load}, 32'h0);
        chk("run_load_req", {31'h0, load_req}, 32'h0);
      end
      load_rdata_valid = 1'b0;
      issue_fetch(1'b1, seq[i], 1'b1);
    end
  endtask

  task automatic run_fetch(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge cpu_clk);
      load_rdata_valid = 1'($urandom_range(0, 1));
      load_rdata       = $urandom;
      issue_fetch(($urandom_range(0, 3) != 0), rand_addr(), 1'b1);
    end
  endtask

  initial begin : stimulus
    for (int i = 0; i < DEPTH; i++) itcm_model[i] = 32'h0;
    new_image();
    img[0] = 32'h11; img[1] = 32'h22; img[2] = 32'h33; img[3] = 32'h44;

    do_reset(3);
    load_image(LW, 0);
    directed_run();
    run_fetch(300);

    new_image();
    do_reset(2);
    load_image(LW, 3);
    directed_run();
    run_fetch(200);

    new_image();
    do_reset(2);
    load_image(2, 1);
    new_image();
    do_reset(2);
    load_image(LW, 1);
    directed_run();
    run_fetch(300);

    @(negedge cpu_clk);
    instr_itcm_access = 1'b0;
    load_rdata_valid  = 1'b0;
    repeat (3) @(negedge cpu_clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
